// File: rtl/vga_pkg.sv
// Shared 800x600@72 raster timing, chessboard geometry and renderer latency
// constants for the VGA display path.
package vga_pkg;

   localparam int H_ACTIVE   = 800;
   localparam int H_FP       = 56;
   localparam int H_SYNC     = 120;
   localparam int H_BP       = 64;
   localparam int V_ACTIVE   = 600;
   localparam int V_FP       = 37;
   localparam int V_SYNC     = 6;
   localparam int V_BP       = 23;
   localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int BOARD_X0   = 60;
   localparam int BOARD_Y0   = 60;
   localparam int SQUARE     = 60;
   localparam int BOARD_N    = 8;

   // BRAM read plus output register in the renderer; hs/vs must match it
   localparam int RENDER_DLY = 2;

   localparam int CNT_W      = 11;
   typedef logic [CNT_W-1:0] cnt_t;

   function automatic logic in_window(input cnt_t cnt, input cnt_t lo, input cnt_t hi);
      return (cnt >= lo) && (cnt < hi);
   endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Parameterised shift register with a reset value; DEPTH=0 is a passthrough.
module sync_delay_line
   import vga_pkg::*;
#(
   parameter int               DEPTH   = RENDER_DLY,
   parameter int               WIDTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign q = d;
      end else begin : g_shift
         logic [WIDTH-1:0] stage_r [DEPTH];

         // Shift chain; reset clears every stage so no stale pulse survives
         always_ff @(posedge pclk) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage_r[i] <= RST_VAL;
               end
            end else begin
               stage_r[0] <= d;
               for (int i = 1; i < DEPTH; i++) begin
                  stage_r[i] <= stage_r[i-1];
               end
            end
         end

         assign q = stage_r[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// 800x600 VGA raster timing generator feeding the chessboard renderer.
// Optional build macro VGA_FRAME_CNT_EN adds the frame_cnt output.
module vga_timing_gen #(
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_FP     = vga_pkg::H_FP,
   parameter int H_SYNC   = vga_pkg::H_SYNC,
   parameter int H_BP     = vga_pkg::H_BP,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_FP     = vga_pkg::V_FP,
   parameter int V_SYNC   = vga_pkg::V_SYNC,
   parameter int V_BP     = vga_pkg::V_BP,
   parameter int SYNC_POL = 1,
   parameter int SYNC_DLY = vga_pkg::RENDER_DLY
) (
   input  logic       pclk,
   input  logic       rst,
   output logic       hen,
   output logic       ven,
   output logic [9:0] px,
   output logic [9:0] py,
   output logic       hs,
   output logic       vs,
   output logic       line_start,
   output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [7:0] frame_cnt
`endif
);

   import vga_pkg::*;

   localparam cnt_t       H_LAST    = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam cnt_t       V_LAST    = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam cnt_t       H_ACT     = cnt_t'(H_ACTIVE);
   localparam cnt_t       V_ACT     = cnt_t'(V_ACTIVE);
   localparam cnt_t       H_SS      = cnt_t'(H_ACTIVE + H_FP);
   localparam cnt_t       H_SE      = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam cnt_t       V_SS      = cnt_t'(V_ACTIVE + V_FP);
   localparam cnt_t       V_SE      = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic       SYNC_ON   = 1'(SYNC_POL);
   localparam logic [1:0] SYNC_IDLE = {~SYNC_ON, ~SYNC_ON};

   cnt_t       hcnt_r, vcnt_r;
   logic       hen_s, ven_s, hs_raw_s, vs_raw_s, line_start_s, frame_start_s;
   logic [9:0] px_s, py_s;
   logic       hs_raw_r, vs_raw_r;
   logic [1:0] sync_q_s;

   // Free-running raster counters; the line wrap carries into the frame count
   always_ff @(posedge pclk) begin
      if (rst) begin
         hcnt_r <= 11'd0;
         vcnt_r <= 11'd0;
      end else if (hcnt_r == H_LAST) begin
         hcnt_r <= 11'd0;
         if (vcnt_r == V_LAST) begin
            vcnt_r <= 11'd0;
         end else begin
            vcnt_r <= vcnt_r + 11'd1;
         end
      end else begin
         hcnt_r <= hcnt_r + 11'd1;
      end
   end

   // Raster decode of the current counter position
   always_comb begin
      hen_s = (hcnt_r < H_ACT);
      ven_s = (vcnt_r < V_ACT);
      if (hen_s) px_s = hcnt_r[9:0]; else px_s = 10'd0;
      if (ven_s) py_s = vcnt_r[9:0]; else py_s = 10'd0;
      if (in_window(hcnt_r, H_SS, H_SE)) hs_raw_s = SYNC_ON; else hs_raw_s = ~SYNC_ON;
      if (in_window(vcnt_r, V_SS, V_SE)) vs_raw_s = SYNC_ON; else vs_raw_s = ~SYNC_ON;
      line_start_s  = (hcnt_r == 11'd0);
      frame_start_s = line_start_s && (vcnt_r == 11'd0);
   end

   // Decode register: every output lags the counters by one pclk
   always_ff @(posedge pclk) begin
      if (rst) begin
         hen         <= 1'b0;
         ven         <= 1'b0;
         px          <= 10'd0;
         py          <= 10'd0;
         hs_raw_r    <= ~SYNC_ON;
         vs_raw_r    <= ~SYNC_ON;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         hen         <= hen_s;
         ven         <= ven_s;
         px          <= px_s;
         py          <= py_s;
         hs_raw_r    <= hs_raw_s;
         vs_raw_r    <= vs_raw_s;
         line_start  <= line_start_s;
         frame_start <= frame_start_s;
      end
   end

   sync_delay_line #(
      .DEPTH   (SYNC_DLY),
      .WIDTH   (2),
      .RST_VAL (SYNC_IDLE)
   ) u_sync_dly (
      .pclk (pclk),
      .rst  (rst),
      .d    ({hs_raw_r, vs_raw_r}),
      .q    (sync_q_s)
   );

   assign hs = sync_q_s[1];
   assign vs = sync_q_s[0];

`ifdef VGA_FRAME_CNT_EN
   // Frame counter advances on the same edge that raises frame_start
   always_ff @(posedge pclk) begin
      if (rst) begin
         frame_cnt <= 8'd0;
      end else if (frame_start_s) begin
         frame_cnt <= frame_cnt + 8'd1;
      end else begin
         frame_cnt <= frame_cnt;
      end
   end
`endif

endmodule
